// File: rtl/fetch_sprime_pkg.sv
// Shared state typedefs and SRAM region offsets for the milestone-2 fetch/write-back blocks.
package fetch_sprime_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } fetchS_state_type;

    localparam logic [17:0] Y_OFFSET    = 18'd0;
    localparam logic [17:0] U_OFFSET    = 18'd38400;
    localparam logic [17:0] V_OFFSET    = 18'd57600;
    localparam logic [17:0] BASE_OFFSET = 18'd76800;

    // Coefficients are stored as signed 16-bit words; DPRAM holds them at 32 bits.
    function automatic logic [31:0] sext16(input logic [15:0] d);
        return {{16{d[15]}}, d};
    endfunction

endpackage

// File: rtl/sprime_addr_gen.sv
// Block-relative coefficient index to SRAM word address for the S' region (320 words per row).
module sprime_addr_gen
    import fetch_sprime_pkg::*;
(
    input  logic [5:0]  col_block_i,
    input  logic [4:0]  row_block_i,
    input  logic [5:0]  k_i,
    output logic [17:0] addr_o
);

    logic [17:0] row_s;
    logic [17:0] col_s;

    // Row times 320 is built from two shifts; everything wraps in 18 bits.
    always_comb begin
        row_s  = {10'd0, row_block_i, 3'd0} + {15'd0, k_i[5:3]};
        col_s  = {9'd0, col_block_i, k_i[2:0]};
        addr_o = BASE_OFFSET + (row_s << 8) + (row_s << 6) + col_s;
    end

endmodule

// File: rtl/fetch_sprime.sv
// Streams one 8x8 S' block from SRAM into DPRAM, row-major, then pulses fetch_done.
module fetch_sprime
    import fetch_sprime_pkg::*;
(
    input  logic        clock,
    input  logic        resetn,
    input  logic        fetch_start,
    output logic        fetch_done,
    input  logic [5:0]  col_block,
    input  logic [4:0]  row_block,
    input  logic [15:0] SRAM_read_data,
    output logic [17:0] SRAM_address,
    output logic        SRAM_we_n,
    output logic [6:0]  dp_address,
    output logic [31:0] dp_write_data,
    output logic        dp_wren
);

    fetchS_state_type state_q, state_d;
    logic [5:0]  col_q, col_d;
    logic [4:0]  row_q, row_d;
    logic [5:0]  i_q, i_d;
    logic [5:0]  w_q, w_d;
    logic [17:0] addr_q, addr_d;
    logic        addr_vld_q, addr_vld_d;
    logic [1:0]  vld_q, vld_d;
    logic [6:0]  dp_addr_q, dp_addr_d;
    logic [31:0] dp_data_q, dp_data_d;
    logic        dp_wren_q, dp_wren_d;
    logic        done_q, done_d;

    logic [5:0]  gen_col_s;
    logic [4:0]  gen_row_s;
    logic [5:0]  gen_k_s;
    logic [17:0] gen_addr_s;

    sprime_addr_gen u_addr_gen (
        .col_block_i (gen_col_s),
        .row_block_i (gen_row_s),
        .k_i         (gen_k_s),
        .addr_o      (gen_addr_s)
    );

    // Next-state, address issue and DPRAM write logic.
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        i_d        = i_q;
        w_d        = w_q;
        addr_d     = addr_q;
        addr_vld_d = 1'b0;
        vld_d      = {vld_q[0], addr_vld_q};
        dp_addr_d  = dp_addr_q;
        dp_data_d  = dp_data_q;
        dp_wren_d  = 1'b0;
        done_d     = 1'b0;
        gen_col_s  = col_q;
        gen_row_s  = row_q;
        gen_k_s    = i_q;

        case (state_q)
            S_IDLE: begin
                // Index 0 is issued on the start edge itself, straight from the block inputs.
                gen_col_s = col_block;
                gen_row_s = row_block;
                gen_k_s   = 6'd0;
                if (fetch_start) begin
                    col_d      = col_block;
                    row_d      = row_block;
                    addr_d     = gen_addr_s;
                    addr_vld_d = 1'b1;
                    i_d        = 6'd1;
                    w_d        = 6'd0;
                    state_d    = S_ISSUE;
                end else begin
                    state_d    = S_IDLE;
                end
            end
            S_ISSUE: begin
                addr_d     = gen_addr_s;
                addr_vld_d = 1'b1;
                i_d        = i_q + 6'd1;
                if (i_q == 6'd63) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_DRAIN: begin
                if (dp_wren_q && (dp_addr_q == 7'd63)) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (vld_q[1]) begin
            dp_wren_d = 1'b1;
            dp_addr_d = {1'b0, w_q};
            dp_data_d = sext16(SRAM_read_data);
            w_d       = w_q + 6'd1;
        end else begin
            dp_wren_d = 1'b0;
        end
    end

    // State and pipeline registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            col_q      <= 6'd0;
            row_q      <= 5'd0;
            i_q        <= 6'd0;
            w_q        <= 6'd0;
            addr_q     <= 18'd0;
            addr_vld_q <= 1'b0;
            vld_q      <= 2'd0;
            dp_addr_q  <= 7'd0;
            dp_data_q  <= 32'd0;
            dp_wren_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            i_q        <= i_d;
            w_q        <= w_d;
            addr_q     <= addr_d;
            addr_vld_q <= addr_vld_d;
            vld_q      <= vld_d;
            dp_addr_q  <= dp_addr_d;
            dp_data_q  <= dp_data_d;
            dp_wren_q  <= dp_wren_d;
            done_q     <= done_d;
        end
    end

    assign SRAM_address  = addr_q;
    assign SRAM_we_n     = 1'b1;
    assign dp_address    = dp_addr_q;
    assign dp_write_data = dp_data_q;
    assign dp_wren       = dp_wren_q;
    assign fetch_done    = done_q;

endmodule
